pwm_ramp_ctrl: RTL and testbench

//  Sequencer that drives the duty input of a PWM generator. Accepts ramp commands

---
 rtl/pwm_ramp_ctrl_if.sv | 28 ++
 rtl/pwm_ramp_ctrl.sv | 123 ++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_ramp_ctrl_if.sv
// Ramp command channel: target duty, step size and dwell count, qualified by
// a valid/ready handshake.
interface pwm_ramp_ctrl_if #(
  parameter int R          = 8,
  parameter int DWELL_BITS = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [R:0]            cmd_target;
  logic [R:0]            cmd_step;
  logic [DWELL_BITS-1:0] cmd_dwell;

  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_step,
    output cmd_dwell,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  cmd_step,
    input  cmd_dwell,
    output cmd_ready
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Moves the PWM duty toward a commanded target in fixed steps, changing it only
// on PWM period boundaries so the generator never sees a mid-period update.
module pwm_ramp_ctrl #(
  parameter int R          = 8,
  parameter int DWELL_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 period_end,
  input  logic                 abort,
  pwm_ramp_ctrl_if.slave       cmd,
  output logic [R:0]           duty,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [R:0]            duty_q, duty_d;
  logic [R:0]            target_q, target_d;
  logic [R:0]            step_q, step_d;
  logic [DWELL_BITS-1:0] dwell_q, dwell_d;
  logic [DWELL_BITS-1:0] dwell_cnt_q, dwell_cnt_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [R+1:0] duty_x, target_x, step_x, dist_x, next_x;

  // One extra bit of headroom so the distance and the stepped value cannot wrap.
  always_comb begin
    duty_x   = {1'b0, duty_q};
    target_x = {1'b0, target_q};
    step_x   = {1'b0, step_q};
    if (target_x >= duty_x) begin
      dist_x = target_x - duty_x;
      next_x = duty_x + step_x;
    end else begin
      dist_x = duty_x - target_x;
      next_x = duty_x - step_x;
    end
  end

  always_comb begin
    state_d     = state_q;
    duty_d      = duty_q;
    target_d    = target_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    dwell_cnt_d = dwell_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd.cmd_valid && cmd_ready_q) begin
          target_d    = cmd.cmd_target;
          step_d      = (cmd.cmd_step == '0) ? (R+1)'(1) : cmd.cmd_step;
          dwell_d     = cmd.cmd_dwell;
          dwell_cnt_d = '0;
          state_d     = (cmd.cmd_target == duty_q) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (period_end) begin
          if (dwell_cnt_q == dwell_q) begin
            dwell_cnt_d = '0;
            if (dist_x <= step_x) begin
              duty_d  = target_q;
              state_d = DONE;
            end else begin
              duty_d = (R+1)'(next_x);
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + DWELL_BITS'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered alongside the state they describe.
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      duty_q      <= '0;
      target_q    <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      dwell_cnt_q <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      target_q    <= target_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      dwell_cnt_q <= dwell_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign duty          = duty_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed-vector bench for pwm_ramp_ctrl with hand-computed duty, handshake
// and done expectations.
`timescale 1ns/1ps
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       period_end;
  logic       abort;
  logic [8:0] duty;
  logic       busy;
  logic       done;

  int vec_count = 0;
  int err_count = 0;

  pwm_ramp_ctrl_if #(.R(8), .DWELL_BITS(8)) cmd_if ();

  pwm_ramp_ctrl #(.R(8), .DWELL_BITS(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .period_end (period_end),
    .abort      (abort),
    .cmd        (cmd_if),
    .duty       (duty),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one command for a single cycle; the controller must be ready for it.
  task automatic applyStimulus(input int target, input int step, input int dwell);
    checkOutput("ready_before_cmd", 32'(cmd_if.cmd_ready), 1);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = 9'(target);
    cmd_if.cmd_step   = 9'(step);
    cmd_if.cmd_dwell  = 8'(dwell);
    tick();
    cmd_if.cmd_valid  = 1'b0;
  endtask

  task automatic pulse(input int gap);
    repeat (gap) tick();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    int exp_duty;
    reset_n           = 1'b0;
    period_end        = 1'b0;
    abort             = 1'b0;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_target = '0;
    cmd_if.cmd_step   = '0;
    cmd_if.cmd_dwell  = '0;
    tick();
    tick();
    checkOutput("rst_duty",  32'(duty), 0);
    checkOutput("rst_ready", 32'(cmd_if.cmd_ready), 1);
    checkOutput("rst_busy",  32'(busy), 0);
    checkOutput("rst_done",  32'(done), 0);
    reset_n = 1'b1;
    tick();

    // Reset in the middle of a ramp, between clock edges
    applyStimulus(100, 40, 0);
    checkOutput("t1_busy",  32'(busy), 1);
    checkOutput("t1_ready", 32'(cmd_if.cmd_ready), 0);
    pulse(16);
    checkOutput("t1_duty40", 32'(duty), 40);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t1_async_duty",  32'(duty), 0);
    checkOutput("t1_async_ready", 32'(cmd_if.cmd_ready), 1);
    checkOutput("t1_async_busy",  32'(busy), 0);
    checkOutput("t1_async_done",  32'(done), 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Ramp up 0 -> 100 in steps of 30, one step per period
    applyStimulus(100, 30, 0);
    for (int i = 1; i <= 3; i++) begin
      pulse(511);
      checkOutput("t2_duty", 32'(duty), 32'(30 * i));
      checkOutput("t2_no_done", 32'(done), 0);
    end
    pulse(511);
    checkOutput("t2_duty100", 32'(duty), 100);
    checkOutput("t2_done",    32'(done), 1);
    checkOutput("t2_ready_in_done", 32'(cmd_if.cmd_ready), 0);
    tick();
    checkOutput("t2_done_clear", 32'(done), 0);
    checkOutput("t2_ready_back", 32'(cmd_if.cmd_ready), 1);
    checkOutput("t2_busy_clear", 32'(busy), 0);

    // Dwell of 2: steps land on the 3rd and 6th period_end
    applyStimulus(90, 5, 2);
    for (int i = 1; i <= 6; i++) begin
      pulse(16);
      exp_duty = (i < 3) ? 100 : ((i < 6) ? 95 : 90);
      checkOutput("t3_duty", 32'(duty), 32'(exp_duty));
    end
    checkOutput("t3_done", 32'(done), 1);
    tick();

    // Bring duty to 10, then a zero step behaves as a step of one
    applyStimulus(10, 100, 0);
    pulse(16);
    checkOutput("t4_duty10", 32'(duty), 10);
    tick();
    applyStimulus(12, 0, 0);
    pulse(16);
    checkOutput("t4_duty11", 32'(duty), 11);
    pulse(0);
    checkOutput("t4_duty12", 32'(duty), 12);
    tick();
    applyStimulus(12, 5, 0);
    checkOutput("t4_same_done", 32'(done), 1);
    checkOutput("t4_same_duty", 32'(duty), 12);
    tick();
    checkOutput("t4_same_ready", 32'(cmd_if.cmd_ready), 1);

    // Abort colliding with a step pulse at duty 60, then immediate new command
    applyStimulus(200, 48, 0);
    pulse(16);
    checkOutput("t5_duty60", 32'(duty), 60);
    repeat (16) tick();
    period_end = 1'b1;
    abort      = 1'b1;
    tick();
    period_end = 1'b0;
    checkOutput("t5_abort_duty",  32'(duty), 60);
    checkOutput("t5_abort_done",  32'(done), 0);
    checkOutput("t5_abort_ready", 32'(cmd_if.cmd_ready), 1);
    checkOutput("t5_abort_busy",  32'(busy), 0);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = 9'd500;
    cmd_if.cmd_step   = 9'd440;
    cmd_if.cmd_dwell  = 8'd0;
    tick();
    cmd_if.cmd_valid = 1'b0;
    abort            = 1'b0;
    checkOutput("t5_accept_ready", 32'(cmd_if.cmd_ready), 0);
    checkOutput("t5_accept_busy",  32'(busy), 1);
    pulse(16);
    checkOutput("t5_duty500", 32'(duty), 500);
    checkOutput("t5_done",    32'(done), 1);
    tick();

    // Saturation at the top with a command held during WAIT
    applyStimulus(511, 300, 0);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = 9'd0;
    cmd_if.cmd_step   = 9'd1;
    repeat (4) tick();
    checkOutput("t6_held_ready", 32'(cmd_if.cmd_ready), 0);
    checkOutput("t6_held_duty",  32'(duty), 500);
    pulse(16);
    checkOutput("t6_duty511", 32'(duty), 511);
    checkOutput("t6_done",    32'(done), 1);
    cmd_if.cmd_valid = 1'b0;
    tick();
    checkOutput("t6_ready", 32'(cmd_if.cmd_ready), 1);
    checkOutput("t6_duty_hold", 32'(duty), 511);

    // Ramp down to zero clamps without wrapping
    applyStimulus(0, 300, 0);
    pulse(16);
    checkOutput("t6_duty211", 32'(duty), 211);
    pulse(16);
    checkOutput("t6_duty0", 32'(duty), 0);
    checkOutput("t6_down_done", 32'(done), 1);
    tick();
    checkOutput("t6_down_ready", 32'(cmd_if.cmd_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
